uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one uart_tx instance between NUM_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes.
- Drives the transmitter's tx_start/tx_data pair and sequences on its tx_done_tick.
- Sits between multiple producers (e.g. status logger, command echo) and the uart_tx unit, in the same clock domain.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and uart_tx control bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_BIT = 8
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*DATA_BIT-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        tx_start;
    logic [DATA_BIT-1:0]         tx_data;
    logic                        tx_done_tick;
    logic                        busy;
    logic [OW-1:0]               owner;

    // master: producers plus the uart_tx unit; slave: the arbiter
    modport master (
        output req_valid, req_data, tx_done_tick,
        input  req_ready, tx_start, tx_data, busy, owner
    );
    modport slave (
        input  req_valid, req_data, tx_done_tick,
        output req_ready, tx_start, tx_data, busy, owner
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ byte producers
// Optional owner lock (contiguous multi-byte messages) enabled by UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_BIT = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
`ifdef UART_TX_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0] req_lock
`endif
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [DATA_BIT-1:0] tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;

    logic                found;
    logic [OW-1:0]       sel;
    logic [OW-1:0]       ptr_adv;
    logic [OW-1:0]       ptr_next;

    // First valid requester at or after ptr, wrapping around
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                sel   = OW'(idx);
            end
        end
    end

    always_comb begin
        ptr_adv = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + OW'(1);
`ifdef UART_TX_ARB_LOCK_EN
        ptr_next = req_lock[owner_q] ? owner_q : ptr_adv;
`else
        ptr_next = ptr_adv;
`endif
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    tx_data_d   = bus.req_data[sel*DATA_BIT +: DATA_BIT];
                    owner_d     = sel;
                    tx_start_d  = 1'b1;
                    req_ready_d = NUM_REQ'(1) << sel;
                    state_d     = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done_tick) begin
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BIT(DW)) bus ();
`ifdef UART_TX_ARB_LOCK_EN
    logic [N-1:0] req_lock;
`endif

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BIT(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef UART_TX_ARB_LOCK_EN
        ,
        .req_lock(req_lock)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [N-1:0]  pend;
    logic [DW-1:0] pdata [N];
    int            model_ptr;

    task automatic drive_reqs();
        bus.req_valid = pend;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pdata[i];
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        drive_reqs();
        bus.tx_done_tick = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        req_lock = '0;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
    endtask

    task automatic wait_start(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max && !ok; c++) begin
            if (bus.tx_start === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_done();
        bus.tx_done_tick = 1'b1;
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
    endtask

    // Winner = first pending requester when scanning a doubled request vector from the pointer
    function automatic int model_pick();
        logic [2*N-1:0] dbl;
        dbl = {pend, pend} >> model_ptr;
        for (int k = 0; k < N; k++)
            if (dbl[k]) return (model_ptr + k) % N;
        return -1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        pend = '1;
        for (int i = 0; i < N; i++) pdata[i] = 8'hFF;
        drive_reqs();
        bus.tx_done_tick = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        req_lock = '0;
`endif
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); else pass_cnt++;
        total_cnt++; if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", bus.owner); else pass_cnt++;
        total_cnt++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else pass_cnt++;
        pend = '0;
        drive_reqs();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        pdata[2] = 8'h41; pend = 4'b0100; drive_reqs();
        @(negedge clk);
        total_cnt++; if (bus.tx_start !== 1'b1) $display("FAIL single_tx_start: got %b want 1", bus.tx_start); else pass_cnt++;
        total_cnt++; if (bus.tx_data !== 8'h41) $display("FAIL single_tx_data: got %h want 41", bus.tx_data); else pass_cnt++;
        total_cnt++; if (bus.req_ready !== 4'b0100) $display("FAIL single_req_ready: got %b want 0100", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.owner !== 2'd2) $display("FAIL single_owner: got %0d want 2", bus.owner); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else pass_cnt++;
        @(negedge clk);
        pend = '0; drive_reqs();
        total_cnt++; if (bus.tx_start !== 1'b0 || bus.req_ready !== 4'b0)
            $display("FAIL single_pulse_width: got start=%b ready=%b want 0/0000", bus.tx_start, bus.req_ready); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy_wait: got %b want 1", bus.busy); else pass_cnt++;
        pulse_done();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_done: got %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [DW-1:0] exp_seq [5];
        exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        for (int i = 0; i < N; i++) pdata[i] = 8'(8'h10 + i);
        pend = 4'b1111; drive_reqs();
        for (int t = 0; t < 5; t++) begin
            if (t == 0) wait_start(5, ok);
            else begin
                total_cnt++; if (bus.tx_start !== 1'b0) $display("FAIL simul_gap%0d: got start=%b want 0", t, bus.tx_start); else pass_cnt++;
                @(negedge clk);
                ok = (bus.tx_start === 1'b1);
            end
            total_cnt++; if (!ok) $display("FAIL simul_start%0d: got no tx_start want tx_start", t); else pass_cnt++;
            total_cnt++; if (bus.tx_data !== exp_seq[t]) $display("FAIL simul_data%0d: got %h want %h", t, bus.tx_data, exp_seq[t]); else pass_cnt++;
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_done();
        end
        pend = '0; drive_reqs();
        @(negedge clk);
        pulse_done();
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        pdata[3] = 8'hC3; pend = 4'b1000; drive_reqs();
        wait_start(5, ok);
        total_cnt++; if (!ok || bus.owner !== 2'd3) $display("FAIL wrap_first: got ok=%b owner=%0d want 1/3", ok, bus.owner); else pass_cnt++;
        @(negedge clk);
        pdata[0] = 8'hC0; pend = 4'b1001; drive_reqs();
        pulse_done();
        wait_start(3, ok);
        total_cnt++; if (!ok || bus.owner !== 2'd0 || bus.tx_data !== 8'hC0)
            $display("FAIL wrap_to_zero: got ok=%b owner=%0d data=%h want 1/0/c0", ok, bus.owner, bus.tx_data); else pass_cnt++;
        @(negedge clk);
        pend = 4'b1000; drive_reqs();
        pulse_done();
        wait_start(3, ok);
        total_cnt++; if (!ok || bus.owner !== 2'd3 || bus.tx_data !== 8'hC3)
            $display("FAIL wrap_then_three: got ok=%b owner=%0d data=%h want 1/3/c3", ok, bus.owner, bus.tx_data); else pass_cnt++;
        @(negedge clk);
        pend = '0; drive_reqs();
        pulse_done();
    endtask

    task automatic test_spurious_done();
        do_reset();
        pulse_done();
        total_cnt++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.req_ready !== 4'b0)
            $display("FAIL spur_idle: got busy=%b start=%b ready=%b want 0/0/0000", bus.busy, bus.tx_start, bus.req_ready); else pass_cnt++;
        pdata[1] = 8'h5A; pend = 4'b0010; drive_reqs();
        @(negedge clk);
        total_cnt++; if (bus.tx_start !== 1'b1) $display("FAIL spur_start: got %b want 1", bus.tx_start); else pass_cnt++;
        bus.tx_done_tick = 1'b1;
        pend = '0; drive_reqs();
        @(negedge clk);
        bus.tx_done_tick = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0)
            $display("FAIL spur_in_start: got busy=%b ready=%b want 1/0000", bus.busy, bus.req_ready); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL spur_still_wait: got %b want 1", bus.busy); else pass_cnt++;
        pulse_done();
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL spur_real_done: got %b want 0", bus.busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.req_ready !== 4'b0 || bus.tx_start !== 1'b0)
            $display("FAIL spur_no_extra: got ready=%b start=%b want 0000/0", bus.req_ready, bus.tx_start); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        pdata[2] = 8'h77; pend = 4'b0100; drive_reqs();
        wait_start(5, ok);
        @(negedge clk);
        pdata[1] = 8'h3C; pend = 4'b0010; drive_reqs();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (bus.tx_start !== 1'b0 || bus.req_ready !== 4'b0 || bus.busy !== 1'b0 || bus.owner !== 2'd0 || bus.tx_data !== 8'h00)
            $display("FAIL midreset_outputs: got start=%b ready=%b busy=%b owner=%0d data=%h want all 0",
                     bus.tx_start, bus.req_ready, bus.busy, bus.owner, bus.tx_data);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.tx_start !== 1'b1 || bus.owner !== 2'd1 || bus.tx_data !== 8'h3C || bus.req_ready !== 4'b0010)
            $display("FAIL midreset_regrant: got start=%b owner=%0d data=%h ready=%b want 1/1/3c/0010",
                     bus.tx_start, bus.owner, bus.tx_data, bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        pend = '0; drive_reqs();
        pulse_done();
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    task automatic test_lock();
        bit ok;
        do_reset();
        pdata[0] = 8'hA0; pdata[1] = 8'hB1; pend = 4'b0011; req_lock = 4'b0001;
        drive_reqs();
        for (int t = 0; t < 3; t++) begin
            wait_start(5, ok);
            total_cnt++; if (!ok || bus.owner !== 2'd0 || bus.tx_data !== 8'(8'hA0 + t))
                $display("FAIL lock_byte%0d: got ok=%b owner=%0d data=%h want 1/0/%h", t, ok, bus.owner, bus.tx_data, 8'(8'hA0 + t));
            else pass_cnt++;
            @(negedge clk);
            pdata[0] = 8'(8'hA1 + t); drive_reqs();
            if (t == 2) req_lock = '0;
            pulse_done();
        end
        wait_start(3, ok);
        total_cnt++; if (!ok || bus.owner !== 2'd1 || bus.tx_data !== 8'hB1)
            $display("FAIL lock_release: got ok=%b owner=%0d data=%h want 1/1/b1", ok, bus.owner, bus.tx_data); else pass_cnt++;
        @(negedge clk);
        pend = '0; drive_reqs();
        pulse_done();
    endtask
`endif

    task automatic test_random();
        bit ok;
        int exp;
        logic [DW-1:0] exp_data;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pdata[i] = 8'($urandom);
                end
            if (pend == '0) begin
                int r;
                r = $urandom_range(0, N - 1);
                pend[r] = 1'b1;
                pdata[r] = 8'($urandom);
            end
            drive_reqs();
            exp = model_pick();
            exp_data = pdata[exp];
            wait_start(5, ok);
            total_cnt++; if (!ok || bus.owner !== 2'(exp) || bus.tx_data !== exp_data || bus.req_ready !== 4'(1 << exp))
                $display("FAIL rand%0d: got ok=%b owner=%0d data=%h ready=%b want 1/%0d/%h/%b",
                         n, ok, bus.owner, bus.tx_data, bus.req_ready, exp, exp_data, 4'(1 << exp));
            else pass_cnt++;
            @(negedge clk);
            pend[exp] = 1'b0; drive_reqs();
            repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef UART_TX_ARB_LOCK_EN
            req_lock = 4'($urandom_range(0, 15));
            model_ptr = req_lock[exp] ? exp : (exp + 1) % N;
`else
            model_ptr = (exp + 1) % N;
`endif
            pulse_done();
        end
        pend = '0; drive_reqs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wrap();
        test_spurious_done();
        test_reset_mid();
`ifdef UART_TX_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
